// File: rtl/oled_pkg.sv
// Shared geometry and FSM encoding for the SSD1306 framebuffer streamer.
package oled_pkg;
  localparam int H_PIXELS    = 128;
  localparam int V_PIXELS    = 64;
  localparam int PAGES       = V_PIXELS / 8;
  localparam int COLS_BYTES  = H_PIXELS / 8;
  localparam int FRAME_BYTES = H_PIXELS * V_PIXELS / 8;

  typedef enum logic [1:0] {IDLE, READ, EMIT, DONE} state_t;
endpackage

// File: rtl/tile_transpose8x8.sv
// Holds one 8x8 tile as eight row bytes and presents column k as a page byte.
// Column byte bit j is row j, pixel k (MSB of a row byte is its leftmost pixel).
module tile_transpose8x8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       cap_en,
  input  logic [2:0] cap_idx,
  input  logic [7:0] cap_dat,
  input  logic [2:0] col_k,
  output logic [7:0] col_byte
);
  logic [7:0] row_q [8];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) row_q[i] <= '0;
    end else if (cap_en) begin
      row_q[cap_idx] <= cap_dat;
    end
  end

  always_comb begin
    col_byte = '0;
    for (int j = 0; j < 8; j++) col_byte[j] = row_q[j][3'd7 - col_k];
  end
endmodule

// File: rtl/fb_ssd1306_streamer.sv
// Streams a 1bpp row-major framebuffer as SSD1306 page bytes, one 8x8 tile at a time.
// Each tile is 9 read cycles followed by 8 valid/ready byte beats.
module fb_ssd1306_streamer #(
  parameter int H_PIXELS = oled_pkg::H_PIXELS,
  parameter int V_PIXELS = oled_pkg::V_PIXELS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  output logic       busy,
  output logic       done,
  output logic       fb_re,
  output logic [7:0] fb_xpos,
  output logic [7:0] fb_ypos,
  input  logic [7:0] fb_dout,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last
);
  import oled_pkg::*;

  localparam int NPAGES = V_PIXELS / 8;
  localparam int NCOLS  = H_PIXELS / 8;
  localparam int PW     = (NPAGES > 1) ? $clog2(NPAGES) : 1;
  localparam int CW     = (NCOLS > 1) ? $clog2(NCOLS) : 1;

  state_t        state_q;
  logic [PW-1:0] p_q;
  logic [CW-1:0] c_q;
  logic [3:0]    r_q;
  logic [2:0]    k_q;
  logic          busy_q, done_q, fb_re_q, m_valid_q, m_last_q;
  logic          last_tile, cap_en;
  logic [2:0]    cap_idx;

  assign last_tile = (p_q == PW'(NPAGES - 1)) && (c_q == CW'(NCOLS - 1));

  // Read data lags the address by one cycle, so READ cycle r stores row r-1.
  assign cap_en  = (state_q == READ) && (r_q != 4'd0);
  assign cap_idx = 3'(r_q - 4'd1);

  tile_transpose8x8 u_tile (
    .clk      (clk),
    .rst      (rst),
    .cap_en   (cap_en),
    .cap_idx  (cap_idx),
    .cap_dat  (fb_dout),
    .col_k    (k_q),
    .col_byte (m_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      p_q       <= '0;
      c_q       <= '0;
      r_q       <= '0;
      k_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fb_re_q   <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            state_q <= READ;
            busy_q  <= 1'b1;
            fb_re_q <= 1'b1;
            p_q     <= '0;
            c_q     <= '0;
            r_q     <= '0;
          end
        end
        READ: begin
          r_q <= r_q + 4'd1;
          if (r_q == 4'd7) fb_re_q <= 1'b0;
          if (r_q == 4'd8) begin
            state_q   <= EMIT;
            k_q       <= '0;
            m_valid_q <= 1'b1;
            m_last_q  <= 1'b0;
          end
        end
        EMIT: begin
          if (m_ready) begin
            k_q      <= k_q + 3'd1;
            m_last_q <= last_tile && (k_q == 3'd6);
            if (k_q == 3'd7) begin
              m_valid_q <= 1'b0;
              m_last_q  <= 1'b0;
              if (last_tile) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                p_q     <= '0;
                c_q     <= '0;
              end else begin
                state_q <= READ;
                fb_re_q <= 1'b1;
                r_q     <= '0;
                if (c_q == CW'(NCOLS - 1)) begin
                  c_q <= '0;
                  p_q <= p_q + 1'b1;
                end else begin
                  c_q <= c_q + 1'b1;
                end
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          r_q     <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign fb_re   = fb_re_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign fb_xpos = 8'(c_q) << 3;
  assign fb_ypos = 8'({p_q, r_q[2:0]});
endmodule

// File: tb/tb_fb_ssd1306_streamer.sv
// Directed bench for fb_ssd1306_streamer: framebuffer model, negedge stream monitor,
// and a golden tile-transpose reference computed from the bench's own pixel array.
module tb_fb_ssd1306_streamer;
  import oled_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_start = 1'b0;
  logic       busy, done, fb_re, m_valid, m_last;
  logic [7:0] fb_xpos, fb_ypos, m_data;
  logic [7:0] fb_dout = 8'h00;
  logic       m_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  bit bp_mode = 1'b0;

  logic [7:0] fb_mem [0:V_PIXELS-1][0:COLS_BYTES-1];

  logic [7:0] hs_dat [$];
  bit         hs_last [$];
  int done_cnt, done_cyc, first_re, first_vld, bad_xpos, stab_viol;
  bit stall_prev;
  logic [7:0] prev_d;
  logic prev_l;

  fb_ssd1306_streamer dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .busy        (busy),
    .done        (done),
    .fb_re       (fb_re),
    .fb_xpos     (fb_xpos),
    .fb_ypos     (fb_ypos),
    .fb_dout     (fb_dout),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    fb_dout <= fb_mem[fb_ypos[5:0]][fb_xpos[6:3]];
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (stall_prev && (!m_valid || m_data !== prev_d || m_last !== prev_l)) stab_viol++;
      if (m_valid && m_ready) begin
        hs_dat.push_back(m_data);
        hs_last.push_back(m_last);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc + 1 - t0;
      end
      if (fb_re && first_re < 0) first_re = cyc + 1 - t0;
      if (m_valid && first_vld < 0) first_vld = cyc + 1 - t0;
      if (fb_re && (fb_xpos[2:0] != 3'd0 || fb_xpos > 8'd120)) bad_xpos++;
      stall_prev = m_valid && !m_ready;
      prev_d = m_data;
      prev_l = m_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    hs_dat.delete();
    hs_last.delete();
    done_cnt = 0; done_cyc = -1; first_re = -1; first_vld = -1;
    bad_xpos = 0; stab_viol = 0; stall_prev = 1'b0;
  endtask

  task automatic fill_fb(input bit rnd);
    for (int y = 0; y < V_PIXELS; y++)
      for (int c = 0; c < COLS_BYTES; c++)
        fb_mem[y][c] = rnd ? 8'($urandom) : 8'h00;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    t0 = cyc;
    frame_start = 1'b0;
  endtask

  task automatic run_frame(input int budget, output bit timed_out);
    clear_mon();
    start_frame();
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    repeat (3) tick();
  endtask

  function automatic logic [7:0] gold(input int i);
    int t, k, p, c;
    logic [7:0] b;
    t = i / 8; k = i % 8; p = t / COLS_BYTES; c = t % COLS_BYTES;
    for (int j = 0; j < 8; j++) b[j] = fb_mem[8*p + j][c][7-k];
    return b;
  endfunction

  function automatic int gold_mism();
    int n = 0;
    for (int i = 0; i < hs_dat.size(); i++) if (hs_dat[i] !== gold(i)) n++;
    return n;
  endfunction

  function automatic int last_count(output int idx);
    int n = 0;
    idx = -1;
    for (int i = 0; i < hs_last.size(); i++) if (hs_last[i]) begin n++; idx = i; end
    return n;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (fb_re !== 1'b0)   begin errors++; $display("FAIL reset_fb_re got %b want 0", fb_re); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    checks++; if (m_last !== 1'b0)  begin errors++; $display("FAIL reset_m_last got %b want 0", m_last); end
    checks++; if (fb_xpos !== 8'h00 || fb_ypos !== 8'h00 || m_data !== 8'h00) begin
      errors++; $display("FAIL reset_regs got x=%h y=%h d=%h want 00 00 00", fb_xpos, fb_ypos, m_data);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_all_zero();
    bit to;
    int lidx, lcnt;
    fill_fb(1'b0);
    run_frame(6000, to);
    checks++; if (to) begin errors++; $display("FAIL zero_timeout got no done want done"); end
    checks++; if (hs_dat.size() !== FRAME_BYTES) begin errors++; $display("FAIL zero_count got %0d want %0d", hs_dat.size(), FRAME_BYTES); end
    checks++; if (gold_mism() !== 0) begin errors++; $display("FAIL zero_data got %0d nonzero bytes want 0", gold_mism()); end
    lcnt = last_count(lidx);
    checks++; if (lcnt !== 1 || lidx !== 1023) begin errors++; $display("FAIL zero_last got cnt=%0d idx=%0d want 1 1023", lcnt, lidx); end
    checks++; if (done_cyc !== 2177) begin errors++; $display("FAIL zero_done_cycle got T+%0d want T+2177", done_cyc); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_cnt got %0d want 1", done_cnt); end
    checks++; if (first_re !== 1) begin errors++; $display("FAIL zero_first_re got T+%0d want T+1", first_re); end
    checks++; if (first_vld !== 10) begin errors++; $display("FAIL zero_first_valid got T+%0d want T+10", first_vld); end
    checks++; if (bad_xpos !== 0) begin errors++; $display("FAIL zero_xpos got %0d bad addresses want 0", bad_xpos); end
  endtask

  task automatic test_single_pixel();
    bit to;
    fill_fb(1'b0);
    fb_mem[0][0] = 8'h80;
    run_frame(6000, to);
    checks++; if (to || hs_dat.size() !== FRAME_BYTES) begin errors++; $display("FAIL px00_count got %0d want %0d", hs_dat.size(), FRAME_BYTES); end
    else begin
      checks++; if (hs_dat[0] !== 8'h01) begin errors++; $display("FAIL px00_byte0 got %h want 01", hs_dat[0]); end
      checks++; if (gold_mism() !== 0) begin errors++; $display("FAIL px00_others got %0d mismatches want 0", gold_mism()); end
    end
  endtask

  task automatic test_corner_pixels();
    bit to;
    fill_fb(1'b0);
    fb_mem[2][1]   = 8'h40;
    fb_mem[63][15] = 8'h01;
    run_frame(6000, to);
    checks++; if (to || hs_dat.size() !== FRAME_BYTES) begin errors++; $display("FAIL corner_count got %0d want %0d", hs_dat.size(), FRAME_BYTES); end
    else begin
      checks++; if (hs_dat[9] !== 8'h04) begin errors++; $display("FAIL px92_byte9 got %h want 04", hs_dat[9]); end
      checks++; if (hs_dat[1023] !== 8'h80 || hs_last[1023] !== 1'b1) begin
        errors++; $display("FAIL px127_63 got %h last=%b want 80 last=1", hs_dat[1023], hs_last[1023]);
      end
      checks++; if (gold_mism() !== 0) begin errors++; $display("FAIL corner_others got %0d mismatches want 0", gold_mism()); end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int lidx, lcnt;
    fill_fb(1'b1);
    bp_mode = 1'b1;
    run_frame(12000, to);
    bp_mode = 1'b0;
    checks++; if (to || hs_dat.size() !== FRAME_BYTES) begin errors++; $display("FAIL bp_count got %0d want %0d", hs_dat.size(), FRAME_BYTES); end
    checks++; if (gold_mism() !== 0) begin errors++; $display("FAIL bp_data got %0d mismatches want 0", gold_mism()); end
    checks++; if (stab_viol !== 0) begin errors++; $display("FAIL bp_stable got %0d stall violations want 0", stab_viol); end
    lcnt = last_count(lidx);
    checks++; if (lcnt !== 1 || lidx !== 1023) begin errors++; $display("FAIL bp_last got cnt=%0d idx=%0d want 1 1023", lcnt, lidx); end
  endtask

  task automatic test_start_ignored();
    bit pulsed = 1'b0;
    bit saw_done = 1'b0;
    fill_fb(1'b1);
    clear_mon();
    start_frame();
    for (int i = 0; i < 6000; i++) begin
      if (!pulsed && hs_dat.size() >= 42) begin
        frame_start = 1'b1; tick(); frame_start = 1'b0; pulsed = 1'b1;
      end else begin
        tick();
      end
      if (done) begin
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        saw_done = 1'b1;
        break;
      end
    end
    repeat (40) tick();
    checks++; if (!saw_done) begin errors++; $display("FAIL ign_timeout got no done want done"); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ign_done_cnt got %0d want 1", done_cnt); end
    checks++; if (hs_dat.size() !== FRAME_BYTES || busy !== 1'b0) begin
      errors++; $display("FAIL ign_single_frame got bytes=%0d busy=%b want %0d 0", hs_dat.size(), busy, FRAME_BYTES);
    end
    checks++; if (gold_mism() !== 0) begin errors++; $display("FAIL ign_data got %0d mismatches want 0", gold_mism()); end
  endtask

  task automatic test_reset_mid_frame();
    bit to;
    int lidx, lcnt;
    fill_fb(1'b1);
    clear_mon();
    start_frame();
    for (int i = 0; i < 6000 && hs_dat.size() < 400; i++) tick();
    checks++; if (hs_dat.size() < 400) begin errors++; $display("FAIL rst_reach_page3 got %0d bytes want >=400", hs_dat.size()); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (busy !== 1'b0 || m_valid !== 1'b0 || fb_re !== 1'b0) begin
      errors++; $display("FAIL rst_abort got busy=%b valid=%b re=%b want 0 0 0", busy, m_valid, fb_re);
    end
    repeat (30) tick();
    lcnt = last_count(lidx);
    checks++; if (done_cnt !== 0 || lcnt !== 0) begin errors++; $display("FAIL rst_no_done got done=%0d last=%0d want 0 0", done_cnt, lcnt); end
    run_frame(6000, to);
    checks++; if (to || hs_dat.size() !== FRAME_BYTES) begin errors++; $display("FAIL rst_refr_count got %0d want %0d", hs_dat.size(), FRAME_BYTES); end
    checks++; if (gold_mism() !== 0 || done_cnt !== 1) begin
      errors++; $display("FAIL rst_refr_data got %0d mismatches done=%0d want 0 1", gold_mism(), done_cnt);
    end
  endtask

  initial begin
    fill_fb(1'b0);
    clear_mon();
    test_reset();
    test_all_zero();
    test_single_pixel();
    test_corner_pixels();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fb_ssd1306_streamer.md
Name: fb_ssd1306_streamer

Overview:
Downstream consumer of the monochrome framebuffer. It reads the 128x64 row-major 1bpp buffer and transposes each 8x8 pixel tile into SSD1306 page/column byte order. It emits one 1024-byte frame over a valid/ready byte stream to the OLED SPI byte sender. A frame is started by a one-cycle request from the display controller FSM.

Parameters:
H_PIXELS, 128, horizontal resolution in pixels; must be a multiple of 8
V_PIXELS, 64, vertical resolution in pixels; must be a multiple of 8

Ports:
clk  input  1  module clock
rst  input  1  reset, synchronous, active-low (asserted when 0, sampled on posedge clk)
frame_start  input  1  one-cycle pulse to begin streaming a frame
busy  output  1  high from frame acceptance until done
done  output  1  one-cycle pulse after the last byte handshake
fb_re  output  1  framebuffer read enable
fb_xpos  output  8  framebuffer X in pixels; always a multiple of 8
fb_ypos  output  8  framebuffer Y in pixels
fb_dout  input  8  framebuffer read data; valid the cycle after fb_re; bit7 = pixel at fb_xpos+0, bit0 = pixel at fb_xpos+7
m_data  output  8  SSD1306 data byte; bit0 = top row of page
m_valid  output  1  m_data valid
m_ready  input  1  sink accepts byte when m_valid and m_ready are high on the same posedge
m_last  output  1  high with the final byte of the frame (byte index 1023)

Behaviour:
- Reset (rst==0): state IDLE. busy, done, fb_re, m_valid and m_last are 0. fb_xpos, fb_ypos and m_data are 0. Tile buffer and counters cleared.
- Reset mid-frame: immediate abort to IDLE, with no done and no m_last. The sink must tolerate a truncated frame.
- Tile order: page p=0..V/8-1 (outer), byte column c=0..H/8-1 (inner). One 8x8 tile per (p,c).
- IDLE: frame_start=1 -> READ with p=0, c=0, busy=1. frame_start is ignored while busy.
- READ: 9 cycles.
  - Cycles 0..7: fb_re=1, fb_xpos=8c, fb_ypos=8p+r for r=0..7.
  - Cycles 1..8: capture fb_dout into row[r] (1-cycle read latency).
  - Cycle 8: fb_re=0. Then -> EMIT with k=0.
- EMIT: m_valid=1 and m_data[j] = row[j][7-k] for j=0..7, which is pixel column x=8c+k.
  - On handshake, k increments.
  - On handshake with k==7: if last tile -> DONE, else -> READ with the next (p,c).
  - m_valid, m_data and m_last must hold stable while m_ready=0. m_valid never drops without a handshake.
- m_last = 1 only in EMIT when p==V/8-1, c==H/8-1 and k==7.
- DONE: one cycle with done=1 and busy=0 -> IDLE. frame_start in this cycle is ignored.
- Timing with m_ready held high: 17 cycles per tile, so 2176 cycles from the first READ cycle to the last handshake.
  - frame_start sampled at cycle T gives fb_re high T+1..T+8, m_valid high T+10..T+17 for the first tile, and done at T+2177.
- Counters: k 3b, r 4b, c and p sized $clog2(H/8) and $clog2(V/8). Wrap only via explicit last-tile detection; no silent overflow.
- Framebuffer writes are not arbitrated here. The upstream owner must not write during busy if a tear-free frame is required.

Decomposition:
- Shared package oled_pkg: H_PIXELS/V_PIXELS defaults, PAGES=V/8, COLS_BYTES=H/8, FRAME_BYTES=H*V/8, and the state enum {IDLE, READ, EMIT, DONE}.
- One natural sub-module: tile_transpose8x8. It holds the 8-byte row capture register and provides combinational column-select k -> column byte. Top level keeps the FSM, counters and handshake.

Test Plan:
- All-zero framebuffer, frame_start, m_ready=1 -> exactly 1024 handshakes, all m_data=0x00, m_last only on byte 1023, done at T+2177, fb_xpos always in {0,8,...,120}.
- Single pixel (0,0) set (fb byte row0/col0 = 0x80) -> byte 0 = 0x01, all others 0x00.
- Pixel (9,2) set (row2/col1 = 0x40) -> byte 9 = 0x04. Pixel (127,63) set (row63/col15 = 0x01) -> byte 1023 = 0x80 with m_last=1.
- Random m_ready backpressure (about 50% duty) on a random framebuffer -> byte stream identical to a golden transpose model; m_data/m_last stable whenever m_valid=1 and m_ready=0.
- frame_start pulsed during EMIT of tile 5, and again in the DONE cycle -> ignored: single frame of 1024 bytes, one done pulse.
- rst=0 for one cycle during page 3 -> next cycle busy=0, m_valid=0, fb_re=0, no done. A following frame_start streams a full correct 1024-byte frame.
